dac_feeder: RTL and testbench
=============================

DAC_FEEDER -- requirements
Module: dac_feeder

Interface
REQ-001 Parameter DEPTH, default 4, sample FIFO depth (power of two, 2..16).
REQ-002 Parameter MIN_PERIOD, default 64, minimum clk cycles between successive dac_start_o rising edges (>=1).
REQ-003 clk_i  in  1  system clock; all logic on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 clear_i  in  1  synchronous FIFO flush, active-high.
REQ-006 sample_i  in  16  signed two's-complement DAC setpoint.
REQ-007 sample_valid_i  in  1  sample_i valid.
REQ-008 sample_ready_o  out  1  FIFO can accept; transfer on valid&&ready at clock edge.
REQ-009 dac_data_o  out  16  signed setpoint presented to DAC writer.
REQ-010 dac_start_o  out  1  start request to DAC writer.
REQ-011 dac_idle_i  in  1  DAC writer idle indication.
REQ-012 update_done_o  out  1  one-cycle pulse when a DAC update completes.
REQ-013 level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 FIFO: DEPTH x 16, first-in first-out; sample_ready_o = (level < DEPTH) && !clear_i, combinational from registered level.
REQ-015 Push when full is impossible (ready low); push and pop in same cycle with level in 1..DEPTH-1 leaves level unchanged; read/write pointers wrap modulo DEPTH.
REQ-016 FSM states: IDLE, START, BUSY, HOLDOFF.
REQ-017 IDLE: if FIFO non-empty, dac_idle_i=1 and holdoff counter=0 -> pop head into dac_data_o, set dac_start_o=1, load holdoff counter with MIN_PERIOD-1, go START (all registered at same edge).
REQ-018 START: dac_start_o held 1 and dac_data_o held stable; when dac_idle_i=0 sampled -> dac_start_o=0, go BUSY.
REQ-019 BUSY: dac_start_o=0; when dac_idle_i=1 sampled -> update_done_o=1 for one cycle, go HOLDOFF.
REQ-020 HOLDOFF: go IDLE when holdoff counter=0; otherwise remain.
REQ-021 Holdoff counter decrements by 1 every cycle while non-zero, in any state, saturating at 0.
REQ-022 dac_data_o changes only on the IDLE->START transition.
REQ-023 Latency: FIFO empty, FSM IDLE, counter 0, writer idle, sample accepted at edge k -> dac_start_o=1 and dac_data_o=sample after edge k+1.
REQ-024 MIN_PERIOD=1: back-to-back updates limited only by writer handshake (one HOLDOFF cycle).
REQ-025 clear_i=1 at edge: level->0, pointers->0, any simultaneous push ignored; FSM and in-flight transfer unaffected (an SPI frame in progress always completes).
REQ-026 clear_i coincident with IDLE->START pop condition: clear wins, no pop, no start.
REQ-027 dac_idle_i never observed low in START: remain START indefinitely (no timeout).

Reset
REQ-028 rst_ni=0 immediately forces: FSM IDLE, dac_start_o=0, dac_data_o=0, update_done_o=0, level_o=0, pointers 0, holdoff counter 0, sample_ready_o=0.
REQ-029 sample_ready_o rises in first cycle after rst_ni deasserted; reset mid-transfer abandons handshake, writer recovers via own reset.

Verification
REQ-030 Single sample 16'sh1234, writer model idle -> dac_start_o high one cycle after acceptance with dac_data_o=16'h1234; drops after dac_idle_i low; update_done_o one pulse when idle returns.
REQ-031 Burst of 6 samples (-32768, -1, 0, 1, 32767, 0x0AAA), DEPTH=4 -> ready low after 4 queued, all 6 emitted in order, level_o never >4.
REQ-032 MIN_PERIOD=64, fast writer (20-cycle frame), FIFO pre-filled -> successive dac_start_o rising edges exactly 64 cycles apart.
REQ-033 clear_i pulse during BUSY with level 3 -> level_o=0 next cycle, current frame completes with update_done_o, no further starts.
REQ-034 rst_ni low during START -> dac_start_o=0, dac_data_o=0, level_o=0 asynchronously; after release new sample handled per REQ-023.
REQ-035 Simultaneous push and pop at level 2 -> level stays 2, data order preserved across pointer wrap.

Source files
------------

// File: rtl/dac_feeder.sv
// -----------------------------------------------------------------------------
// dac_feeder
//   Buffers signed 16-bit DAC setpoints in a small FIFO and hands them one at a
//   time to a DAC writer through a start/idle handshake. Successive starts are
//   spaced at least MIN_PERIOD clock cycles apart.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   clear_i         synchronous FIFO flush (does not touch a transfer in flight)
//   sample_i        signed setpoint to enqueue
//   sample_valid_i  sample_i is valid; transfer on valid && ready
//   sample_ready_o  FIFO can accept a sample this cycle
//   dac_data_o      setpoint presented to the DAC writer
//   dac_start_o     start request to the DAC writer
//   dac_idle_i      DAC writer is idle
//   update_done_o   one-cycle pulse when the writer finishes an update
//   level_o         current FIFO occupancy
// -----------------------------------------------------------------------------
module dac_feeder #(
   parameter int DEPTH      = 4,
   parameter int MIN_PERIOD = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,
   input  logic signed [15:0]        sample_i,
   input  logic                      sample_valid_i,
   output logic                      sample_ready_o,
   output logic signed [15:0]        dac_data_o,
   output logic                      dac_start_o,
   input  logic                      dac_idle_i,
   output logic                      update_done_o,
   output logic [$clog2(DEPTH):0]    level_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(MIN_PERIOD) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_BUSY,
      S_HOLDOFF
   } state_t;

   state_t                 state_q, state_d;
   logic signed [15:0]     mem [DEPTH];
   logic [PW-1:0]          wr_ptr, rd_ptr;
   logic [LW-1:0]          level_q;
   logic [CW-1:0]          hold_cnt;
   logic                   push, pop;
   logic                   start_d, done_d;

   // Ready is gated by rst_ni so it is low throughout reset and rises as soon
   // as reset is released.
   assign sample_ready_o = rst_ni && (level_q < LW'(DEPTH)) && !clear_i;
   assign push           = sample_valid_i && sample_ready_o;
   assign level_o        = level_q;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      state_d = state_q;
      start_d = dac_start_o;
      done_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A clear in the same cycle wins: no pop, no start.
            if ((level_q != '0) && dac_idle_i && (hold_cnt == '0) && !clear_i) begin
               pop     = 1'b1;
               start_d = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            // Waits for the writer to go busy, with no timeout.
            if (!dac_idle_i) begin
               start_d = 1'b0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (dac_idle_i) begin
               done_d  = 1'b1;
               state_d = S_HOLDOFF;
            end
         end
         S_HOLDOFF: begin
            // Leave one cycle early so IDLE sees the counter reach zero on the
            // very edge the period expires; starts then land exactly
            // MIN_PERIOD cycles apart rather than MIN_PERIOD+1.
            if (hold_cnt <= CW'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         dac_start_o   <= 1'b0;
         update_done_o <= 1'b0;
         dac_data_o    <= '0;
      end else begin
         state_q       <= state_d;
         dac_start_o   <= start_d;
         update_done_o <= done_d;
         // The only place the presented setpoint changes.
         if (pop) dac_data_o <= mem[rd_ptr];
      end
   end

   // ------------------------------------------------------ holdoff counter
   // Loaded on every start; counts down in any state and saturates at zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_cnt <= '0;
      end else if (pop) begin
         hold_cnt <= CW'(MIN_PERIOD - 1);
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt - CW'(1);
      end
   end

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (clear_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // NOTE: the storage array has no reset; entries are only read after being
   // written, and leaving it out lets the array map onto plain RAM/flops.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= sample_i;
   end

endmodule

// File: tb/tb_dac_feeder.sv
// -----------------------------------------------------------------------------
// tb_dac_feeder
//   Self-checking bench for dac_feeder (DEPTH=4, MIN_PERIOD=64). A queue-based
//   reference model predicts every output each cycle; directed scenarios add
//   hand-computed literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_dac_feeder;

   localparam int DEPTH      = 4;
   localparam int MIN_PERIOD = 64;
   localparam int LW         = $clog2(DEPTH) + 1;

   logic               clk_i          = 1'b0;
   logic               rst_ni         = 1'b0;
   logic               clear_i        = 1'b0;
   logic signed [15:0] sample_i       = '0;
   logic               sample_valid_i = 1'b0;
   logic               sample_ready_o;
   logic signed [15:0] dac_data_o;
   logic               dac_start_o;
   logic               dac_idle_i;
   logic               update_done_o;
   logic [LW-1:0]      level_o;

   // Writer: either an automatic frame model or a level forced by the main flow.
   bit   wr_auto  = 1'b0;
   bit   wr_force = 1'b1;
   int   wr_frame = 5;      // 0 selects a random frame length per transfer
   logic w_idle   = 1'b1;
   assign dac_idle_i = wr_auto ? w_idle : wr_force;

   dac_feeder #(.DEPTH(DEPTH), .MIN_PERIOD(MIN_PERIOD)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .sample_i       (sample_i),
      .sample_valid_i (sample_valid_i),
      .sample_ready_o (sample_ready_o),
      .dac_data_o     (dac_data_o),
      .dac_start_o    (dac_start_o),
      .dac_idle_i     (dac_idle_i),
      .update_done_o  (update_done_o),
      .level_o        (level_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   // Behaviour expressed as: a sample queue, whether a start is outstanding,
   // whether the writer frame is running, and the edge numbers of the last
   // start and last completion. A new start may happen on edge n only if the
   // writer is idle, the queue is non-empty, no clear is present, at least
   // MIN_PERIOD edges have passed since the previous start and at least two
   // edges have passed since the previous completion.
   shortint mq[$];
   bit      m_start = 1'b0;
   bit      m_busy  = 1'b0;
   bit      m_done  = 1'b0;
   shortint m_data  = 0;
   longint  edge_n  = 0;
   longint  last_pop  = -1000;
   longint  last_done = -1000;

   always @(posedge clk_i or negedge rst_ni) begin
      bit mpush, mpop, done_now;
      if (!rst_ni) begin
         mq.delete();
         m_start   = 1'b0;
         m_busy    = 1'b0;
         m_done    = 1'b0;
         m_data    = 0;
         last_pop  = -1000;
         last_done = -1000;
      end else begin
         edge_n++;
         mpush = sample_valid_i && (mq.size() < DEPTH) && !clear_i;
         mpop  = !m_start && !m_busy && (mq.size() > 0) && dac_idle_i && !clear_i &&
                 (edge_n >= last_done + 2) && (edge_n >= last_pop + MIN_PERIOD);
         done_now = 1'b0;
         if (m_start) begin
            if (!dac_idle_i) begin
               m_start = 1'b0;
               m_busy  = 1'b1;
            end
         end else if (m_busy) begin
            if (dac_idle_i) begin
               m_busy    = 1'b0;
               done_now  = 1'b1;
               last_done = edge_n;
            end
         end
         if (clear_i) begin
            mq.delete();
         end else begin
            if (mpop) begin
               m_data   = mq.pop_front();
               m_start  = 1'b1;
               last_pop = edge_n;
            end
            if (mpush) mq.push_back(sample_i);
         end
         m_done = done_now;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk_i) begin
      check("start", dac_start_o, m_start);
      check("data", dac_data_o, m_data);
      check("done", update_done_o, m_done);
      check("level", level_o, mq.size());
      check("ready", sample_ready_o, rst_ni && (mq.size() < DEPTH) && !clear_i);
   end

   // ------------------------------------------------------------- monitor
   longint  cyc = 0;
   bit      prev_start = 1'b0;
   shortint rise_data[$];
   longint  rise_t[$];
   int      done_cnt = 0;
   int      lvl_hist[$];

   always @(posedge clk_i) cyc++;

   always @(negedge clk_i) begin
      if (dac_start_o && !prev_start) begin
         rise_data.push_back(dac_data_o);
         rise_t.push_back(cyc);
      end
      prev_start = dac_start_o;
      if (update_done_o) done_cnt++;
      lvl_hist.push_back(int'(level_o));
   end

   // ------------------------------------------------------- writer model
   initial begin
      int ph  = 0;
      int cnt = 0;
      forever begin
         @(negedge clk_i);
         #1;
         if (!wr_auto || !rst_ni) begin
            w_idle = 1'b1;
            ph     = 0;
         end else begin
            case (ph)
               0: if (dac_start_o) begin
                     cnt = $urandom_range(0, 3);
                     ph  = 1;
                  end
               1: if (cnt == 0) begin
                     w_idle = 1'b0;
                     cnt    = (wr_frame > 0) ? wr_frame : $urandom_range(1, 30);
                     ph     = 2;
                  end else cnt--;
               default: if (cnt <= 1) begin
                     w_idle = 1'b1;
                     ph     = 0;
                  end else cnt--;
            endcase
         end
      end
   end

   // ------------------------------------------------------------- helpers
   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic push(input shortint val);
      bit acc = 1'b0;
      sample_i       = val;
      sample_valid_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         acc = sample_ready_o;
         tick();
         if (acc) break;
      end
      sample_valid_i = 1'b0;
      check("push_accepted", acc, 1);
   endtask

   task automatic wait_start(input bit v, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (dac_start_o == v) break;
         tick();
      end
      check("wait_start", dac_start_o, v);
   endtask

   task automatic wait_done(input int d0, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > d0) break;
         tick();
      end
      ticks(3);
      check("done_pulses", done_cnt - d0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      shortint burst[6];
      int      r0, d0, h0, mx;
      burst = '{-32768, -1, 0, 1, 32767, 16'sh0AAA};

      // Reset state.
      ticks(3);
      check("rst_start", dac_start_o, 0);
      check("rst_data", dac_data_o, 0);
      check("rst_done", update_done_o, 0);
      check("rst_level", level_o, 0);
      check("rst_ready", sample_ready_o, 0);
      rst_ni = 1'b1;
      #1;
      check("ready_after_rst", sample_ready_o, 1);
      tick();

      // Single sample, latency and handshake.
      wr_auto  = 1'b1;
      wr_frame = 5;
      d0 = done_cnt;
      push(16'sh1234);
      check("t1_level", level_o, 1);
      check("t1_start_early", dac_start_o, 0);
      tick();
      check("t1_start", dac_start_o, 1);
      check("t1_data", dac_data_o, 16'sh1234);
      wait_start(1'b0, 50);
      wait_done(d0, 100);
      ticks(70);

      // Burst into a depth-4 FIFO, 20-cycle writer frames, start spacing.
      wr_frame = 20;
      r0 = rise_t.size();
      h0 = lvl_hist.size();
      foreach (burst[i]) push(burst[i]);
      ticks(6 * MIN_PERIOD + 40);
      check("burst_count", rise_t.size() - r0, 6);
      if (rise_t.size() - r0 >= 6) begin
         for (int i = 0; i < 6; i++) begin
            check($sformatf("burst_data%0d", i), rise_data[r0 + i], burst[i]);
            if (i > 0) check($sformatf("burst_gap%0d", i), rise_t[r0 + i] - rise_t[r0 + i - 1], 64);
         end
      end
      mx = 0;
      for (int i = h0; i < lvl_hist.size(); i++) if (lvl_hist[i] > mx) mx = lvl_hist[i];
      check("burst_max_level", mx, 4);
      ticks(70);

      // Clear while the writer is busy with level 3.
      for (int i = 0; i < 4; i++) push(shortint'(16'h0100 + i));
      wait_start(1'b0, 50);
      check("clr_level_before", level_o, 3);
      d0 = done_cnt;
      r0 = rise_t.size();
      clear_i = 1'b1;
      #1;
      check("clr_ready", sample_ready_o, 0);
      @(negedge clk_i);
      check("clr_level_after", level_o, 0);
      #1;
      clear_i = 1'b0;
      ticks(200);
      check("clr_done_pulses", done_cnt - d0, 1);
      check("clr_no_starts", rise_t.size() - r0, 0);

      // Writer never acknowledges; asynchronous reset in START.
      wr_auto  = 1'b0;
      wr_force = 1'b1;
      push(16'sh0200);
      push(16'sh0201);
      push(16'sh0202);
      ticks(100);
      check("stuck_start", dac_start_o, 1);
      check("stuck_data", dac_data_o, 16'sh0200);
      check("stuck_level", level_o, 2);
      #2;
      rst_ni = 1'b0;
      #1;
      check("arst_start", dac_start_o, 0);
      check("arst_data", dac_data_o, 0);
      check("arst_level", level_o, 0);
      check("arst_ready", sample_ready_o, 0);
      ticks(2);
      rst_ni  = 1'b1;
      wr_auto = 1'b1;
      tick();
      d0 = done_cnt;
      push(16'sh5A5A);
      tick();
      check("post_rst_start", dac_start_o, 1);
      check("post_rst_data", dac_data_o, 16'sh5A5A);
      wait_done(d0, 100);
      ticks(80);

      // Advance pointers, then push and pop together at level 2 across a wrap.
      wr_auto  = 1'b0;
      wr_force = 1'b0;
      push(16'sh0300);
      push(16'sh0301);
      wr_auto = 1'b1;
      ticks(200);
      wr_auto  = 1'b0;
      wr_force = 1'b0;
      push(16'sh0401);
      push(16'sh0402);
      check("pp_level_before", level_o, 2);
      check("pp_model_pin", mq.size(), 2);
      r0 = rise_t.size();
      wr_force       = 1'b1;
      sample_i       = 16'sh0403;
      sample_valid_i = 1'b1;
      tick();
      sample_valid_i = 1'b0;
      check("pp_level_after", level_o, 2);
      check("pp_start", dac_start_o, 1);
      check("pp_data", dac_data_o, 16'sh0401);
      wr_auto = 1'b1;
      ticks(3 * MIN_PERIOD + 60);
      check("pp_count", rise_t.size() - r0, 3);
      if (rise_t.size() - r0 >= 3) begin
         check("pp_order0", rise_data[r0], 16'sh0401);
         check("pp_order1", rise_data[r0 + 1], 16'sh0402);
         check("pp_order2", rise_data[r0 + 2], 16'sh0403);
      end

      // Randomized traffic, random frame lengths and occasional clears.
      wr_frame = 0;
      for (int i = 0; i < 4000; i++) begin
         sample_valid_i = ($urandom_range(0, 2) != 0);
         sample_i       = 16'($urandom);
         clear_i        = ($urandom_range(0, 79) == 0);
         tick();
      end
      sample_valid_i = 1'b0;
      clear_i        = 1'b0;
      ticks(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
